jt49_dcrm_mc: RTL

//  Multi-channel DC-removal filter for the PSG output path. Keeps a 2^AW-sample

---
 rtl/jt49_dcrm_mc.sv | 127 ++++++++++++
 1 files changed

// File: rtl/jt49_dcrm_mc.sv
// Multi-channel DC-removal filter: per-channel 2^AW-sample moving average, output = sample - average.
// Optional macro JT49_DCRM_SAT_EN clamps dout to the DW-bit signed range.
module jt49_dcrm_mc #(
  parameter int DW = 10,
  parameter int AW = 5,
  parameter int CH = 3,
  parameter int CW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [DW-1:0]        din,
  input  logic [CW-1:0]        din_ch,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [DW:0]   dout,
  output logic [CW-1:0]        dout_ch,
  output logic                 dout_valid
);

  localparam int DEPTH  = CH << AW;
  localparam int ADDR_W = CW + AW;
  localparam int SW     = DW + AW;

  typedef enum logic [1:0] {CLEAR, IDLE, READ, UPDATE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       ptr [CH];
  logic [SW-1:0]       sum [CH];

  logic [DW-1:0]       samp_p0;
  logic [CW-1:0]       ch_p0;
  logic [DW-1:0]       old_p1;
  logic [DW-1:0]       avg;
  logic signed [DW:0]  diff;
  logic                accept;
  logic                ch_ok;

  function automatic logic signed [DW:0] sat_dw(input logic signed [DW:0] v);
    logic signed [DW:0] hi;
    logic signed [DW:0] lo;
    hi = {2'b00, {(DW-1){1'b1}}};
    lo = {2'b11, {(DW-1){1'b0}}};
    if (v > hi)      sat_dw = hi;
    else if (v < lo) sat_dw = lo;
    else             sat_dw = v;
  endfunction

  assign ch_ok  = {1'b0, din_ch} < (CW+1)'(CH);
  assign accept = cen & din_valid & din_ready;

  // The window sum cannot underflow: old_p1 is itself part of sum[ch_p0].
  assign avg  = DW'((sum[ch_p0] + SW'(samp_p0) - SW'(old_p1)) >> AW);
  assign diff = $signed({1'b0, samp_p0}) - $signed({1'b0, avg});

  // Stage p0: latch the accepted sample (invalid channels are dropped here)
  always_ff @(posedge clk) begin
    if (accept && ch_ok) begin
      samp_p0 <= din;
      ch_p0   <= din_ch;
    end
  end

  // Stage p1: registered read of the oldest sample; buffer writes for clear and update
  always_ff @(posedge clk) begin
    if (!rst && cen) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (state == UPDATE)
        mem[{ch_p0, ptr[ch_p0]}] <= samp_p0;
      if (accept && ch_ok)
        old_p1 <= mem[{din_ch, ptr[din_ch]}];
    end
  end

  // Stage p2: control FSM, running sums, pointers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      din_ready  <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        ptr[i] <= '0;
        sum[i] <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      if (cen) begin
        case (state)
          CLEAR: begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == ADDR_W'(DEPTH-1)) begin
              state     <= IDLE;
              din_ready <= 1'b1;
            end
          end
          IDLE: begin
            if (din_valid && ch_ok) begin
              state     <= READ;
              din_ready <= 1'b0;
            end
          end
          READ: state <= UPDATE;
          UPDATE: begin
            sum[ch_p0] <= sum[ch_p0] + SW'(samp_p0) - SW'(old_p1);
            ptr[ch_p0] <= ptr[ch_p0] + AW'(1);
`ifdef JT49_DCRM_SAT_EN
            dout       <= sat_dw(diff);
`else
            dout       <= diff;
`endif
            dout_ch    <= ch_p0;
            dout_valid <= 1'b1;
            state      <= IDLE;
            din_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
